// File: rtl/ip4_tlb_arb.sv
// rtl/ip4_tlb_arb.sv - arbitrates translation requesters onto one in-order TLB port.
// Define IP4_TLBARB_FIXPRIO_EN to replace round-robin with fixed lowest-index priority.
module ip4_tlb_arb #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 4,
  parameter int VA_W    = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ-1:0][VA_W-1:0]  req_vadr,
  input  logic [NUM_REQ-1:0][2:0]       req_tid,
  input  logic [NUM_REQ-1:0]            req_k,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ-1:0]            flush,
  output logic                          tlb_en,
  output logic [VA_W-1:0]               tlb_vadr,
  output logic [2:0]                    tlb_tid,
  output logic                          tlb_k,
  input  logic                          tlb_rsp_en,
  input  logic [VA_W-1:0]               tlb_rsp_padr,
  input  logic                          tlb_rsp_exc,
  output logic [NUM_REQ-1:0]            rsp_en,
  output logic [VA_W-1:0]               rsp_padr,
  output logic                          rsp_exc,
  output logic                          err
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ID_W-1:0]  fifoId   [DEPTH];
  logic             fifoDrop [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count;
`ifndef IP4_TLBARB_FIXPRIO_EN
  logic [ID_W-1:0]  rrPtr;
`endif

  logic [NUM_REQ-1:0] eligible;
  logic               full, push, pop, popDrop;
  logic [ID_W-1:0]    gntId, popId;

  assign full     = (count == CNT_W'(DEPTH));
  assign eligible = req_vld & ~flush;

  // A pop in the same cycle never frees a slot for a grant: full is taken from the registered count.
  always_comb begin
    int  idx;
    logic found;
    req_rdy = '0;
    gntId   = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef IP4_TLBARB_FIXPRIO_EN
      idx = k;
`else
      idx = (int'(rrPtr) + k) % NUM_REQ;
`endif
      if (!found && !full && eligible[idx]) begin
        req_rdy[idx] = 1'b1;
        gntId        = ID_W'(idx);
        found        = 1'b1;
      end
    end
  end

  assign push    = |(req_rdy & req_vld);
  assign pop     = tlb_rsp_en && (count != '0);
  assign popId   = fifoId[rdPtr];
  // A flush landing on the very cycle its entry pops still suppresses the response.
  assign popDrop = fifoDrop[rdPtr] | flush[popId];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        fifoId[e]   <= '0;
        fifoDrop[e] <= 1'b0;
      end
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
`ifndef IP4_TLBARB_FIXPRIO_EN
      rrPtr    <= '0;
`endif
      err      <= 1'b0;
      tlb_en   <= 1'b0;
      tlb_vadr <= '0;
      tlb_tid  <= '0;
      tlb_k    <= 1'b0;
      rsp_en   <= '0;
      rsp_padr <= '0;
      rsp_exc  <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (flush[fifoId[e]]) fifoDrop[e] <= 1'b1;
      end
      if (push) begin
        fifoId[wrPtr]   <= gntId;
        fifoDrop[wrPtr] <= flush[gntId];
        wrPtr           <= wrPtr + 1'b1;
        tlb_vadr        <= req_vadr[gntId];
        tlb_tid         <= req_tid[gntId];
        tlb_k           <= req_k[gntId];
`ifndef IP4_TLBARB_FIXPRIO_EN
        rrPtr           <= ID_W'((int'(gntId) + 1) % NUM_REQ);
`endif
      end
      tlb_en <= push;

      if (pop) rdPtr <= rdPtr + 1'b1;
      if (tlb_rsp_en && count == '0) err <= 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      rsp_en <= '0;
      if (pop && !popDrop) begin
        rsp_en   <= NUM_REQ'(1) << popId;
        rsp_padr <= tlb_rsp_padr;
        rsp_exc  <= tlb_rsp_exc;
      end
    end
  end

endmodule

// File: tb/tb_ip4_tlb_arb.sv
// tb/tb_ip4_tlb_arb.sv - directed vector bench for ip4_tlb_arb.
module tb_ip4_tlb_arb;

  localparam logic [19:0] VA0 = 20'h00A00;
  localparam logic [19:0] VA1 = 20'h12345;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_vld = '0;
  logic [1:0][19:0] req_vadr;
  logic [1:0][2:0]  req_tid;
  logic [1:0]       req_k = 2'b10;
  logic [1:0]       req_rdy;
  logic [1:0]       flush = '0;
  logic             tlb_en;
  logic [19:0]      tlb_vadr;
  logic [2:0]       tlb_tid;
  logic             tlb_k;
  logic             tlb_rsp_en = 1'b0;
  logic [19:0]      tlb_rsp_padr = '0;
  logic             tlb_rsp_exc = 1'b0;
  logic [1:0]       rsp_en;
  logic [19:0]      rsp_padr;
  logic             rsp_exc;
  logic             err;

  int nVec = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  ip4_tlb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_vadr(req_vadr), .req_tid(req_tid), .req_k(req_k),
    .req_rdy(req_rdy), .flush(flush),
    .tlb_en(tlb_en), .tlb_vadr(tlb_vadr), .tlb_tid(tlb_tid), .tlb_k(tlb_k),
    .tlb_rsp_en(tlb_rsp_en), .tlb_rsp_padr(tlb_rsp_padr), .tlb_rsp_exc(tlb_rsp_exc),
    .rsp_en(rsp_en), .rsp_padr(rsp_padr), .rsp_exc(rsp_exc), .err(err)
  );

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  fl;
    logic        rsp;
    logic [19:0] padr;
    logic        exc;
    logic [1:0]  rdy;
    logic        tlbEn;
    logic [19:0] tlbVadr;
    logic [1:0]  rspEn;
    logic [19:0] rspPadr;
    logic        rspExc;
    logic        err;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(logic [1:0] vld, logic [1:0] fl, logic rsp, logic [19:0] padr,
                              logic exc, logic [1:0] rdy, logic tlbEn, logic [19:0] tlbVadr,
                              logic [1:0] rspEn, logic [19:0] rspPadr, logic rspExc, logic e);
    vec_t v;
    v.vld = vld; v.fl = fl; v.rsp = rsp; v.padr = padr; v.exc = exc;
    v.rdy = rdy; v.tlbEn = tlbEn; v.tlbVadr = tlbVadr;
    v.rspEn = rspEn; v.rspPadr = rspPadr; v.rspExc = rspExc; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    req_vadr[0] = VA0;
    req_vadr[1] = VA1;
    req_tid[0]  = 3'd2;
    req_tid[1]  = 3'd5;

    //          vld   fl    rsp padr      exc rdy   tE VA   rspEn rspPadr   rX err
    tbl[0]  = mk(2'b00,2'b00,0,20'h0,    0, 2'b00,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[1]  = mk(2'b11,2'b00,0,20'h0,    0, 2'b01,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[2]  = mk(2'b11,2'b00,0,20'h0,    0, 2'b10,1,VA0,  2'b00,20'h0,    0, 0);
    tbl[3]  = mk(2'b11,2'b00,0,20'h0,    0, 2'b01,1,VA1,  2'b00,20'h0,    0, 0);
    tbl[4]  = mk(2'b11,2'b00,0,20'h0,    0, 2'b10,1,VA0,  2'b00,20'h0,    0, 0);
    tbl[5]  = mk(2'b11,2'b00,0,20'h0,    0, 2'b00,1,VA1,  2'b00,20'h0,    0, 0);
    tbl[6]  = mk(2'b11,2'b00,1,20'h00111,0, 2'b00,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[7]  = mk(2'b11,2'b00,0,20'h0,    0, 2'b01,0,20'h0,2'b01,20'h00111,0, 0);
    tbl[8]  = mk(2'b00,2'b00,1,20'h00222,1, 2'b00,1,VA0,  2'b00,20'h0,    0, 0);
    tbl[9]  = mk(2'b00,2'b00,1,20'h00333,0, 2'b00,0,20'h0,2'b10,20'h00222,1, 0);
    tbl[10] = mk(2'b00,2'b00,0,20'h0,    0, 2'b00,0,20'h0,2'b01,20'h00333,0, 0);
    tbl[11] = mk(2'b01,2'b00,0,20'h0,    0, 2'b01,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[12] = mk(2'b00,2'b01,1,20'h00444,0, 2'b00,1,VA0,  2'b00,20'h0,    0, 0);
    tbl[13] = mk(2'b00,2'b00,1,20'h00555,0, 2'b00,0,20'h0,2'b10,20'h00444,0, 0);
    tbl[14] = mk(2'b00,2'b00,1,20'h00666,0, 2'b00,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[15] = mk(2'b10,2'b00,0,20'h0,    0, 2'b10,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[16] = mk(2'b00,2'b00,0,20'h0,    0, 2'b00,1,VA1,  2'b00,20'h0,    0, 0);
    tbl[17] = mk(2'b00,2'b00,1,20'h0ABCD,0, 2'b00,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[18] = mk(2'b00,2'b00,0,20'h0,    0, 2'b00,0,20'h0,2'b10,20'h0ABCD,0, 0);
    tbl[19] = mk(2'b01,2'b00,0,20'h0,    0, 2'b01,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[20] = mk(2'b11,2'b01,1,20'h00777,0, 2'b10,1,VA0,  2'b00,20'h0,    0, 0);
    tbl[21] = mk(2'b00,2'b00,0,20'h0,    0, 2'b00,1,VA1,  2'b00,20'h0,    0, 0);
    tbl[22] = mk(2'b00,2'b00,1,20'h00888,1, 2'b00,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[23] = mk(2'b00,2'b00,0,20'h0,    0, 2'b00,0,20'h0,2'b10,20'h00888,1, 0);
    tbl[24] = mk(2'b00,2'b00,1,20'h00999,0, 2'b00,0,20'h0,2'b00,20'h0,    0, 0);
    tbl[25] = mk(2'b00,2'b00,0,20'h0,    0, 2'b00,0,20'h0,2'b00,20'h0,    0, 1);
    tbl[26] = mk(2'b00,2'b00,0,20'h0,    0, 2'b00,0,20'h0,2'b00,20'h0,    0, 1);

    // Reset state, sampled while rst_n is held low.
    req_vld = 2'b11;
    #2;
    check("reset_tlb_en",   32'(tlb_en),   32'h0);
    check("reset_tlb_vadr", 32'(tlb_vadr), 32'h0);
    check("reset_rsp_en",   32'(rsp_en),   32'h0);
    check("reset_rsp_padr", 32'(rsp_padr), 32'h0);
    check("reset_err",      32'(err),      32'h0);
    req_vld = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

`ifndef IP4_TLBARB_FIXPRIO_EN
    for (int i = 0; i < 27; i++) begin
      req_vld      = tbl[i].vld;
      flush        = tbl[i].fl;
      tlb_rsp_en   = tbl[i].rsp;
      tlb_rsp_padr = tbl[i].padr;
      tlb_rsp_exc  = tbl[i].exc;
      #1;
      check($sformatf("v%0d_req_rdy", i), 32'(req_rdy), 32'(tbl[i].rdy));
      check($sformatf("v%0d_tlb_en", i),  32'(tlb_en),  32'(tbl[i].tlbEn));
      if (tbl[i].tlbEn)
        check($sformatf("v%0d_tlb_vadr", i), 32'(tlb_vadr), 32'(tbl[i].tlbVadr));
      check($sformatf("v%0d_rsp_en", i), 32'(rsp_en), 32'(tbl[i].rspEn));
      if (tbl[i].rspEn != 2'b00) begin
        check($sformatf("v%0d_rsp_padr", i), 32'(rsp_padr), 32'(tbl[i].rspPadr));
        check($sformatf("v%0d_rsp_exc", i),  32'(rsp_exc),  32'(tbl[i].rspExc));
      end
      check($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].err));
      @(negedge clk);
    end

    // Three requests in flight, then a mid-operation reset.
    tlb_rsp_en = 1'b0;
    flush      = 2'b00;
    req_vld    = 2'b01;
    repeat (3) @(negedge clk);
    check("pre_reset_tlb_en", 32'(tlb_en), 32'h1);
    req_vld = 2'b11;
    rst_n   = 1'b0;
    #1;
    check("mid_reset_tlb_en",   32'(tlb_en),   32'h0);
    check("mid_reset_tlb_vadr", 32'(tlb_vadr), 32'h0);
    check("mid_reset_rsp_padr", 32'(rsp_padr), 32'h0);
    check("mid_reset_rsp_exc",  32'(rsp_exc),  32'h0);
    check("mid_reset_err",      32'(err),      32'h0);
    check("mid_reset_rdy",      32'(req_rdy),  32'h1);
    @(negedge clk);
    rst_n      = 1'b1;
    req_vld    = 2'b00;
    tlb_rsp_en = 1'b1;
    @(negedge clk);
    tlb_rsp_en = 1'b0;
    #1;
    check("post_reset_rsp_err", 32'(err),    32'h1);
    check("post_reset_rsp_en",  32'(rsp_en), 32'h0);
`else
    for (int i = 0; i < 3; i++) begin
      req_vld = 2'b11;
      #1;
      check($sformatf("fix%0d_req_rdy", i), 32'(req_rdy), 32'h1);
      if (i > 0) check($sformatf("fix%0d_tlb_vadr", i), 32'(tlb_vadr), 32'(VA0));
      @(negedge clk);
    end
    req_vld = 2'b00;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/ip4_tlb_arb.md
IP4_TLB_ARB -- requirements
Module: ip4_tlb_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, 2, number of translation requesters (index 0 = DSE, 1 = IFE).
REQ-002 SHALL have parameter DEPTH, 4, maximum outstanding translations (power of two).
REQ-003 SHALL have parameter VA_W, 20, virtual page number width.
REQ-004 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_vld  in  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_vadr  in  NUM_REQ x VA_W  requested virtual page.
REQ-008 SHALL have port req_tid  in  NUM_REQ x 3  thread id.
REQ-009 SHALL have port req_k  in  NUM_REQ  kernel privilege.
REQ-010 SHALL have port req_rdy  out  NUM_REQ  grant; a request is accepted when req_vld and req_rdy are both high.
REQ-011 SHALL have port flush  in  NUM_REQ  discard all in-flight translations of that requester.
REQ-012 SHALL have port tlb_en / tlb_vadr / tlb_tid / tlb_k  out  1 / VA_W / 3 / 1  registered request to the TLB.
REQ-013 SHALL have port tlb_rsp_en / tlb_rsp_padr / tlb_rsp_exc  in  1 / VA_W / 1  in-order TLB response.
REQ-014 SHALL have port rsp_en  out  NUM_REQ  one-hot response strobe routed to the owning requester.
REQ-015 SHALL have port rsp_padr / rsp_exc  out  VA_W / 1  registered response payload.
REQ-016 SHALL have port err  out  1  sticky: a TLB response arrived with no outstanding entry.

Function
REQ-017 SHALL grant at most one requester per cycle; req_rdy is combinational from req_vld, flush, the RR pointer and the count.
REQ-018 SHALL deassert all req_rdy when outstanding count equals DEPTH; a same-cycle response pop SHALL NOT enable a grant (no bypass).
REQ-019 SHALL deassert req_rdy[i] in any cycle where flush[i] is high.
REQ-020 SHALL use round-robin: after granting i, requester (i+1) mod NUM_REQ has highest priority; the pointer is unchanged when nothing is granted.
REQ-021 SHALL drive tlb_en and the payload one cycle after acceptance, for exactly one cycle per accepted request.
REQ-022 SHALL push {requester id, drop=0} into an in-order tag FIFO on acceptance and pop it on tlb_rsp_en.
REQ-023 SHALL drive rsp_en[id], rsp_padr and rsp_exc one cycle after tlb_rsp_en, unless the popped entry has drop=1, in which case rsp_en stays 0.
REQ-024 SHALL set drop=1 on every valid FIFO entry owned by i when flush[i] is high, including an entry pushed in the same cycle by another requester only if it is owned by i (never, per REQ-019).
REQ-025 SHALL support a simultaneous push and pop in one cycle with the count unchanged; pointers wrap modulo DEPTH.
REQ-026 SHALL, on tlb_rsp_en with an empty FIFO, set err, ignore the response and leave the count at 0.
REQ-027 SHALL keep a flush of an entry that is being popped in the same cycle effective (rsp_en suppressed).

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear the FIFO, count, and err; set the RR pointer to 0; and drive tlb_en, rsp_en, and all payload outputs to 0.
REQ-029 SHALL treat responses arriving after a mid-operation reset as an empty-FIFO case (REQ-026).

Configuration
REQ-030 SHALL, when IP4_TLBARB_FIXPRIO_EN is defined, replace round-robin with fixed priority (lowest index wins) and omit the RR pointer; without the macro, REQ-020 applies.

Verification
REQ-031 SHALL cover: both requesters hold req_vld for 4 cycles, no responses -> grants alternate 0,1,0,1; tlb_en high for 4 cycles, each 1 cycle after acceptance.
REQ-032 SHALL cover: 4 accepted requests, no response -> req_rdy = 0; response and new request in the same cycle -> no grant that cycle, grant next cycle.
REQ-033 SHALL cover: requester 1 accepts with vadr 0x12345; TLB returns padr 0x0ABCD, exc 0 two cycles later -> rsp_en = 2'b10 and rsp_padr = 0x0ABCD one cycle later.
REQ-034 SHALL cover: two requester-0 entries in flight; flush[0] pulsed -> both responses are consumed, rsp_en stays 0, and a subsequent requester-1 response is delivered.
REQ-035 SHALL cover: tlb_rsp_en with an empty FIFO -> err = 1 until reset; reset asserted with 3 entries in flight -> count 0, all outputs 0.
REQ-036 SHALL cover: with IP4_TLBARB_FIXPRIO_EN, both requesters valid for 3 cycles -> requester 0 is granted every cycle.
